uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_if.sv | 9 +
 rtl/sync_fifo.sv | 65 ++++++
 rtl/uart_rx_fifo.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared receiver definitions: FSM state encoding, parity modes and the
// bit-period calculation used by uart_rx_fifo.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } rx_state_e;

  function automatic int unsigned calc_pulse_width(input int unsigned clk_freq,
                                                   input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_if.sv
// Serial line bundle; word carries the payload on the driving side.
interface uart_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  sig;
  logic [DATA_WIDTH-1:0] word;

  modport rx (input sig);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a push into a full FIFO lands only when a pop
// frees a slot in the same cycle.
module sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en_c;
  logic             rd_en_c;
  logic [AW:0]      count_d;

  assign rd_en_c  = pop && !empty;
  assign wr_en_c  = push && (!full || rd_en_c);
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_d = count;
    if (wr_en_c && !rd_en_c) begin
      count_d = count + CW'(1);
    end else if (rd_en_c && !wr_en_c) begin
      count_d = count - CW'(1);
    end
  end

  // Storage is cleared on reset so the head word reads zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        mem[AW'(i)] <= '0;
      end
    end else begin
      if (wr_en_c) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd_en_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_d;
      full  <= (count_d == CW'(DEPTH));
      empty <= (count_d == '0);
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with mid-bit sampling, optional parity and stop checking,
// feeding received words into a show-ahead FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_if.rx                            rxif,
  input  logic                          sensor_ready,
  output logic [DATA_WIDTH-1:0]         sensor_data,
  output logic                          sensor_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun_err
);

  localparam int unsigned PULSE_WIDTH = calc_pulse_width(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_WIDTH  = PULSE_WIDTH / 2;
  localparam int unsigned CNT_W       = $clog2(PULSE_WIDTH + 1);
  localparam int unsigned BIT_W       = 4;

  localparam logic [CNT_W-1:0] PW_LAST   = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] PW_FULL   = CNT_W'(PULSE_WIDTH);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_WIDTH - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  rx_state_e             state_q, state_d;
  logic                  rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CNT_W-1:0]      tick_q, tick_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_bad_q, par_bad_d;
  logic [CNT_W-1:0]      idle_cnt_q;
  logic                  armed_q;
  logic                  fall_c, exp_par_c, push_c, pop_c;
  logic                  frame_err_d, parity_err_d;
  logic                  fifo_full, fifo_empty;

  assign fall_c       = rx_prev_q && !rx_sync_q;
  assign exp_par_c    = (PARITY == PARITY_ODD) ? ~(^shift_q) : ^shift_q;
  assign sensor_valid = !fifo_empty;
  assign pop_c        = sensor_valid && sensor_ready;

  // Synchroniser and edge history; idle-high so reset never fakes a start.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rxif.sig;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Starts are only honoured once the line has been high for longer than one
  // bit, so a reset mid-frame cannot lock onto that frame's data edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_q <= '0;
      armed_q    <= 1'b0;
    end else begin
      if (!rx_sync_q) begin
        idle_cnt_q <= '0;
      end else if (idle_cnt_q != PW_FULL) begin
        idle_cnt_q <= idle_cnt_q + CNT_W'(1);
      end
      if (rx_sync_q && (idle_cnt_q == PW_FULL)) begin
        armed_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      par_bad_q   <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      par_bad_q   <= par_bad_d;
      frame_err   <= frame_err_d;
      parity_err  <= parity_err_d;
      overrun_err <= push_c && fifo_full && !pop_c;
    end
  end

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q + CNT_W'(1);
    bit_d        = bit_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    push_c       = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tick_d = '0;
        if (fall_c && armed_q) begin
          state_d   = S_START;
          bit_d     = '0;
          par_bad_d = 1'b0;
        end
      end
      S_START: begin
        if (tick_q == HALF_LAST) begin
          tick_d  = '0;
          state_d = rx_sync_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick_q == PW_LAST) begin
          tick_d  = '0;
          shift_d = {rx_sync_q, shift_q[DATA_WIDTH-1:1]};
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (tick_q == PW_LAST) begin
          tick_d    = '0;
          par_bad_d = (rx_sync_q != exp_par_c);
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (tick_q == PW_LAST) begin
          tick_d = '0;
          if (!rx_sync_q) begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_IDLE;
          end else if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            if (par_bad_q) begin
              parity_err_d = 1'b1;
            end else begin
              push_c = 1'b1;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      S_WAIT_IDLE: begin
        if (!rx_sync_q) begin
          tick_d = '0;
        end else if (tick_q == PW_LAST) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_c),
    .push_data (shift_q),
    .pop       (pop_c),
    .pop_data  (sensor_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: dut_a (no parity) and dut_b (even parity), both 4 deep,
// 16 clocks per bit.
module tb_uart_rx_fifo;

  localparam int unsigned PW = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       ready_a, ready_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic [2:0] cnt_a, cnt_b;
  logic       fe_a, pe_a, ov_a, fe_b, pe_b, ov_b;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fe_a = 0, n_pe_a = 0, n_ov_a = 0, n_pe_b = 0;
  int fe0, pe0, ov0;

  uart_if #(.DATA_WIDTH(8)) if_a ();
  uart_if #(.DATA_WIDTH(8)) if_b ();

  always #5 clk = ~clk;

  uart_rx_fifo #(.DATA_WIDTH(8), .BAUD_RATE(10), .CLK_FREQ(160), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .rxif(if_a), .sensor_ready(ready_a),
    .sensor_data(data_a), .sensor_valid(valid_a), .fifo_count(cnt_a),
    .frame_err(fe_a), .parity_err(pe_a), .overrun_err(ov_a));

  uart_rx_fifo #(.DATA_WIDTH(8), .BAUD_RATE(10), .CLK_FREQ(160), .PARITY(1),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .rxif(if_b), .sensor_ready(ready_b),
    .sensor_data(data_b), .sensor_valid(valid_b), .fifo_count(cnt_b),
    .frame_err(fe_b), .parity_err(pe_b), .overrun_err(ov_b));

  // Pulse counters: a one-cycle pulse adds exactly one.
  always @(posedge clk) begin
    if (fe_a) n_fe_a++;
    if (pe_a) n_pe_a++;
    if (ov_a) n_ov_a++;
    if (pe_b) n_pe_b++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic bit_time(input int unsigned n);
    repeat (n * PW) @(negedge clk);
  endtask

  task automatic set_line(input bit sel, input logic v);
    if (sel) if_b.sig = v;
    else if_a.sig = v;
  endtask

  // One frame starting on a negedge; pop_mid_stop pulses ready_a for the
  // single clock on which the stop-bit sample pushes the word.
  task automatic send(input bit sel, input logic [7:0] d, input bit with_par,
                      input logic par, input logic stop, input bit pop_mid_stop);
    if (sel) if_b.word = d;
    else if_a.word = d;
    set_line(sel, 1'b0);
    bit_time(1);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, sel ? if_b.word[i] : if_a.word[i]);
      bit_time(1);
    end
    if (with_par) begin
      set_line(sel, par);
      bit_time(1);
    end
    set_line(sel, stop);
    for (int j = 1; j <= int'(PW); j++) begin
      @(negedge clk);
      if (pop_mid_stop && j == 10) ready_a = 1'b1;
      if (pop_mid_stop && j == 11) ready_a = 1'b0;
    end
    set_line(sel, 1'b1);
  endtask

  task automatic pop_one(input bit sel, input logic [7:0] exp, input string tag);
    check(tag, sel ? data_b : data_a, exp);
    if (sel) ready_b = 1'b1;
    else ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
    ready_b = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ready_a = 1'b0; ready_b = 1'b0;
    if_a.sig = 1'b1; if_b.sig = 1'b1; if_a.word = '0; if_b.word = '0;
    repeat (3) @(negedge clk);
    check("rst_count", cnt_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_data", data_a, 0);
    check("rst_errs", {fe_a, pe_a, ov_a}, 0);
    rst = 1'b0;
    bit_time(3);

    // In-order delivery with a held ready.
    send(0, 8'hA5, 0, 0, 1, 0); bit_time(1);
    send(0, 8'h5A, 0, 0, 1, 0); bit_time(1);
    send(0, 8'hFF, 0, 0, 1, 0); bit_time(1);
    check("three_count", cnt_a, 3);
    check("three_valid", valid_a, 1);
    check("three_head_held", data_a, 8'hA5);
    ready_a = 1'b1;
    check("pop_a5", data_a, 8'hA5);
    @(negedge clk); check("pop_5a", data_a, 8'h5A);
    @(negedge clk); check("pop_ff", data_a, 8'hFF);
    @(negedge clk); check("drained_valid", valid_a, 0);
    check("drained_count", cnt_a, 0);
    ready_a = 1'b0;

    // Overrun on the fifth byte into a 4-deep FIFO.
    ov0 = n_ov_a;
    for (int k = 1; k <= 4; k++) begin
      send(0, 8'(k), 0, 0, 1, 0); bit_time(1);
    end
    check("fill_no_overrun", n_ov_a - ov0, 0);
    check("fill_count", cnt_a, 4);
    send(0, 8'h05, 0, 0, 1, 0); bit_time(1);
    check("overrun_once", n_ov_a - ov0, 1);
    check("overrun_count", cnt_a, 4);
    pop_one(0, 8'h01, "ovr_w1");
    pop_one(0, 8'h02, "ovr_w2");
    pop_one(0, 8'h03, "ovr_w3");
    pop_one(0, 8'h04, "ovr_w4");
    check("ovr_empty", valid_a, 0);

    // Framing error, then recovery once the line idles.
    fe0 = n_fe_a;
    send(0, 8'h3C, 0, 0, 0, 0); bit_time(2);
    check("frame_err_pulse", n_fe_a - fe0, 1);
    check("frame_no_push", cnt_a, 0);
    send(0, 8'h81, 0, 0, 1, 0); bit_time(1);
    check("after_frame_count", cnt_a, 1);
    check("after_frame_fe", n_fe_a - fe0, 1);
    pop_one(0, 8'h81, "after_frame_data");

    // Short start glitch is rejected silently.
    fe0 = n_fe_a; pe0 = n_pe_a; ov0 = n_ov_a;
    set_line(0, 1'b0);
    repeat (PW / 4) @(negedge clk);
    set_line(0, 1'b1);
    bit_time(2);
    check("glitch_count", cnt_a, 0);
    check("glitch_errs", (n_fe_a - fe0) + (n_pe_a - pe0) + (n_ov_a - ov0), 0);
    send(0, 8'h42, 0, 0, 1, 0); bit_time(1);
    pop_one(0, 8'h42, "glitch_then_rx");

    // Push and pop on the same cycle while full.
    for (int k = 0; k < 4; k++) begin
      send(0, 8'h10 + 8'(k), 0, 0, 1, 0); bit_time(1);
    end
    check("full_count", cnt_a, 4);
    ov0 = n_ov_a;
    send(0, 8'h14, 0, 0, 1, 1); bit_time(1);
    check("pushpop_no_ovr", n_ov_a - ov0, 0);
    check("pushpop_count", cnt_a, 4);
    pop_one(0, 8'h11, "pushpop_w1");
    pop_one(0, 8'h12, "pushpop_w2");
    pop_one(0, 8'h13, "pushpop_w3");
    pop_one(0, 8'h14, "pushpop_w4");

    // Reset in the middle of a byte with a word already buffered.
    send(0, 8'h77, 0, 0, 1, 0); bit_time(1);
    check("pre_rst_count", cnt_a, 1);
    fe0 = n_fe_a;
    fork
      send(0, 8'h55, 0, 0, 1, 0);
      begin
        repeat (3 * PW + 5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_count", cnt_a, 0);
        check("midrst_valid", valid_a, 0);
        check("midrst_data", data_a, 0);
        check("midrst_errs", {fe_a, pe_a, ov_a}, 0);
        rst = 1'b0;
      end
    join
    bit_time(2);
    check("post_rst_no_push", cnt_a, 0);
    send(0, 8'h81, 0, 0, 1, 0); bit_time(1);
    check("post_rst_count", cnt_a, 1);
    check("post_rst_fe", n_fe_a - fe0, 0);
    pop_one(0, 8'h81, "post_rst_data");

    // Even parity on dut_b: 0xC3 has even weight, so the parity bit must be 0.
    bit_time(2);
    pe0 = n_pe_b;
    send(1, 8'hC3, 1, 1'b1, 1, 0); bit_time(1);
    check("parity_err_pulse", n_pe_b - pe0, 1);
    check("parity_no_push", cnt_b, 0);
    send(1, 8'hC3, 1, 1'b0, 1, 0); bit_time(1);
    check("parity_ok_count", cnt_b, 1);
    check("parity_ok_pe", n_pe_b - pe0, 1);
    pop_one(1, 8'hC3, "parity_ok_data");
    check("parity_b_fe", fe_b | ov_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
